// File: rtl/rr_mux_4_1_stage.sv
// Registered round-robin 4:1 channel-select stage: combinational rotating-priority
// arbiter, 2-bit-slice data mux, and a single-entry output register with valid/ready.

module rr_mux_slice_2b (
  input  logic [1:0] sel_i,
  input  logic [1:0] d0_i,
  input  logic [1:0] d1_i,
  input  logic [1:0] d2_i,
  input  logic [1:0] d3_i,
  output logic [1:0] y_o
);

  always_comb begin
    y_o = d0_i;
    case (sel_i)
      2'd0:    y_o = d0_i;
      2'd1:    y_o = d1_i;
      2'd2:    y_o = d2_i;
      2'd3:    y_o = d3_i;
      default: y_o = d0_i;
    endcase
  end

endmodule

module rr_mux_4_1_stage #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       in_valid,
  output logic [3:0]       in_ready,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_sel
);

  localparam int unsigned NCH    = 4;
  localparam int unsigned SELW   = 2;
  localparam int unsigned NSLICE = WIDTH / 2;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [SELW-1:0]   sel_q, sel_d;
  logic [SELW-1:0]   ptr_q, ptr_d;

  logic [SELW-1:0]   grant;
  logic [SELW-1:0]   idx;
  logic              found;
  logic              any_req;
  logic              load_en;
  logic [WIDTH-1:0]  d_sel;

  // Rotating-priority search starting at ptr_q; first requester wins.
  always_comb begin
    grant   = '0;
    idx     = '0;
    found   = 1'b0;
    any_req = |in_valid;
    for (int unsigned k = 0; k < NCH; k++) begin
      idx = ptr_q + SELW'(k);
      if (!found && in_valid[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end

  for (genvar k = 0; k < NSLICE; k++) begin : g_slice
    rr_mux_slice_2b u_slice (
      .sel_i (grant),
      .d0_i  (d0[2*k+1:2*k]),
      .d1_i  (d1[2*k+1:2*k]),
      .d2_i  (d2[2*k+1:2*k]),
      .d3_i  (d3[2*k+1:2*k]),
      .y_o   (d_sel[2*k+1:2*k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  // Output register may load whenever it is empty or draining this cycle.
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    sel_d    = sel_q;
    ptr_d    = ptr_q;
    in_ready = '0;
    load_en  = (state_q == EMPTY) || out_ready;
    if (load_en) begin
      if (any_req) begin
        state_d         = FULL;
        data_d          = d_sel;
        sel_d           = grant;
        ptr_d           = grant + SELW'(1);
        in_ready[grant] = rst_n;
      end else begin
        state_d = EMPTY;
      end
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign out_sel   = sel_q;

endmodule

// File: tb/tb_rr_mux_4_1_stage.sv
// Directed bench for rr_mux_4_1_stage: reset, round-robin order, backpressure,
// wrap/skip, sparse single-channel streaming and asynchronous mid-run reset.

module tb_rr_mux_4_1_stage;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] in_valid;
  logic [3:0] in_ready;
  logic [3:0] d0, d1, d2, d3;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic [1:0] out_sel;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  rr_mux_4_1_stage #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .d0        (d0),
    .d1        (d1),
    .d2        (d2),
    .d3        (d3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [3:0] d, input logic [1:0] s);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".out_data"},  32'(out_data),  32'(d));
    chk({tag, ".out_sel"},   32'(out_sel),   32'(s));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered at posedge+1 with inputs already driven: check in_ready, clock, check outputs.
  task automatic cycle(input string tag, input logic [3:0] rdy, input logic v,
                       input logic [3:0] d, input logic [1:0] s);
    #1;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(rdy));
    tick();
    chk_out(tag, v, d, s);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    d0 = 4'h0; d1 = 4'h0; d2 = 4'h0; d3 = 4'h0;

    #2;
    chk("rst.in_ready", 32'(in_ready), 32'h0);
    chk_out("rst", 1'b0, 4'h0, 2'd0);
    tick();
    chk("rst_edge.in_ready", 32'(in_ready), 32'h0);
    in_valid = 4'b0000;
    rst_n    = 1'b1;

    for (int i = 0; i < 5; i++) cycle("idle", 4'b0000, 1'b0, 4'h0, 2'd0);

    in_valid = 4'b1111;
    d0 = 4'h1; d1 = 4'h2; d2 = 4'h4; d3 = 4'h8;
    for (int i = 0; i < 6; i++)
      cycle("rr", 4'(4'b0001 << (i % 4)), 1'b1, 4'(4'b0001 << (i % 4)), 2'(i % 4));

    in_valid = 4'b0100;
    d2 = 4'hA;
    cycle("bp_load", 4'b0100, 1'b1, 4'hA, 2'd2);
    out_ready = 1'b0;
    in_valid  = 4'b1111;
    for (int i = 0; i < 3; i++) cycle("bp_hold", 4'b0000, 1'b1, 4'hA, 2'd2);
    out_ready = 1'b1;
    cycle("bp_release", 4'b1000, 1'b1, 4'h8, 2'd3);

    in_valid = 4'b0100;
    cycle("wrap_pre", 4'b0100, 1'b1, 4'hA, 2'd2);
    in_valid = 4'b0101;
    cycle("wrap_ch0", 4'b0001, 1'b1, 4'h1, 2'd0);
    cycle("skip_ch2", 4'b0100, 1'b1, 4'hA, 2'd2);

    in_valid = 4'b0010;
    d1 = 4'h5;
    for (int i = 0; i < 4; i++) cycle("sparse", 4'b0010, 1'b1, 4'h5, 2'd1);

    out_ready = 1'b0;
    in_valid  = 4'b0000;
    cycle("pre_rst", 4'b0000, 1'b1, 4'h5, 2'd1);
    #1;
    rst_n    = 1'b0;
    in_valid = 4'b1111;
    #1;
    chk_out("async_rst", 1'b0, 4'h0, 2'd0);
    chk("async_rst.in_ready", 32'(in_ready), 32'h0);
    tick();
    chk_out("rst_hold", 1'b0, 4'h0, 2'd0);
    in_valid  = 4'b0110;
    out_ready = 1'b1;
    rst_n     = 1'b1;
    cycle("post_rst", 4'b0010, 1'b1, 4'h5, 2'd1);
    cycle("post_rst2", 4'b0100, 1'b1, 4'hA, 2'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
